// File: rtl/ab_stim_pkg.sv
// Shared types and helpers for the a/b stimulus sequencer.
// Pattern lookup maps a sequence position to the {b,a} stimulus pair.
package ab_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  // Gray order is the reflected code: 00, 01, 11, 10.
  function automatic logic [1:0] pattern(input logic [1:0] pos, input logic mode);
    if (mode == MODE_GRAY) begin
      return {pos[1], pos[1] ^ pos[0]};
    end
    return pos;
  endfunction

endpackage

// File: rtl/ab_stim_seq_hold_counter.sv
// Up-counter with synchronous clear and enable; wraps to zero when enabled
// at its terminal count, which is flagged on tc_o.
module hold_counter #(
  parameter int CNT_W = 8,
  parameter int TERM  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == CNT_W'(TERM));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ab_stim_seq.sv
// Stimulus sequencer: walks the {b,a} combinations in binary or Gray order,
// holding each for HOLD_CYCLES and repeating REPEAT passes per run.
module ab_stim_seq
  import ab_stim_pkg::*;
#(
  parameter int NUM_STEPS   = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int REPEAT      = 1,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       pause,
  output logic       a,
  output logic       b,
  output logic [1:0] step_idx,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  ab_q, ab_d;
  logic        mode_q, mode_d;
  logic        wrap_q, wrap_d;

  logic        in_drive;
  logic        last_step;
  logic        hold_en;
  logic        hold_tc;
  logic        rep_tc;

  assign in_drive  = (state_q == DRIVE);
  assign last_step = (step_q == 2'(NUM_STEPS - 1));
  assign hold_en   = in_drive && !pause;

  hold_counter #(.CNT_W(CNT_W), .TERM(HOLD_CYCLES - 1)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_drive),
    .en_i  (hold_en),
    .tc_o  (hold_tc)
  );

  // The repeat counter only moves when a full pass completes.
  hold_counter #(.CNT_W(CNT_W), .TERM(REPEAT - 1)) u_repeat (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_drive),
    .en_i  (hold_en && hold_tc && last_step),
    .tc_o  (rep_tc)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          mode_d  = mode;
          step_d  = 2'd0;
        end
      end
      DRIVE: begin
        if (hold_en && hold_tc) begin
          if (!last_step) begin
            step_d = step_q + 2'd1;
          end else if (rep_tc) begin
            state_d = DONE;
            step_d  = 2'd0;
          end else begin
            step_d = 2'd0;
            wrap_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = 2'd0;
      end
      default: begin
        state_d = IDLE;
        step_d  = 2'd0;
      end
    endcase
    ab_d = (state_d == DRIVE) ? pattern(step_d, mode_d) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      ab_q    <= 2'b00;
      mode_q  <= MODE_BIN;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ab_q    <= ab_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  assign a        = ab_q[0];
  assign b        = ab_q[1];
  assign step_idx = step_q;
  assign busy     = in_drive;
  assign done     = (state_q == DONE);
  assign wrap     = wrap_q;

endmodule

// File: doc/ab_stim_seq.md
Name: ab_stim_seq

Overview:
Synthesizable stimulus sequencer that sits directly upstream of the analysis_test core and drives its a/b inputs. It walks the four input combinations in a selectable order, holding each for a programmable number of cycles and repeating a programmable number of times. It replaces hand-written delay stimulus, so flow-analysis runs get deterministic, cycle-exact input traces with start/done handshaking.

Parameters:
NUM_STEPS, 4, combinations per pass (legal 1..4); pass covers sequence positions 0..NUM_STEPS-1
HOLD_CYCLES, 1, cycles each combination is held (legal >=1)
REPEAT, 1, number of passes per run (legal >=1)
CNT_W, 8, width of hold and repeat counters; HOLD_CYCLES and REPEAT must fit

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request a run; sampled only in IDLE
mode  in  1  0 = binary order, 1 = Gray order; latched on accepted start
pause  in  1  freezes hold, step and repeat counters while high in DRIVE
a  out  1  stimulus bit to downstream a
b  out  1  stimulus bit to downstream b
step_idx  out  2  current sequence position
busy  out  1  high throughout DRIVE
done  out  1  one-cycle pulse at end of run
wrap  out  1  one-cycle pulse on the first cycle of every pass after the first

Behaviour:
- Reset (synchronous, any state, including mid-run): state=IDLE; a=b=0, step_idx=0, busy=done=wrap=0; all counters cleared; latched mode=0.
- States: IDLE, DRIVE, DONE.
- IDLE: start=1 at edge N -> edge N latches mode and enters DRIVE. From cycle N+1: busy=1, step_idx=0, {b,a}=pattern(0).
- Pattern, all as {b,a}. Binary: pos0=00, pos1=01, pos2=10, pos3=11, i.e. a=pos[0], b=pos[1]. Gray: pos0=00, pos1=01, pos2=11, pos3=10.
- DRIVE, pause=0: hold counter increments each cycle. When it reaches HOLD_CYCLES-1, it clears and step advances.
- Step advance, normal: step_idx+1.
- Step advance at NUM_STEPS-1 with passes remaining: step_idx=0 and repeat count+1. wrap=1 during the first cycle of the new pass.
- Step advance at NUM_STEPS-1 on the final pass: next state is DONE.
- DRIVE, pause=1: all counters, step_idx, a and b hold; busy stays 1. A pause asserted on the terminal cycle delays the transition to DONE.
- Unpaused run length: exactly NUM_STEPS*HOLD_CYCLES*REPEAT DRIVE cycles.
- DONE: lasts exactly one cycle. done=1, busy=0, a=b=0, step_idx=0. Next state is IDLE unconditionally; start during DONE is ignored.
- start while busy: ignored; no restart and no effect on mode.
- start=1 and pause=1 in the same IDLE cycle: start is accepted; DRIVE holds pos0 for as long as pause stays high.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package ab_stim_pkg: state enum (IDLE, DRIVE, DONE), mode constants MODE_BIN=0 and MODE_GRAY=1, pattern lookup function pos->{b,a} for both modes.
- One sub-module, hold_counter: CNT_W-bit up-counter with clear, enable and terminal-count output. Instantiated twice, once for hold cycles and once for repeat passes.
- Top holds the FSM, step register and output registers.

Test Plan:
- Defaults, mode=0, start pulse at cycle 2 -> cycles 3..6 show {b,a}=00,01,10,11 with busy=1; cycle 7 shows done=1, a=b=0; cycle 8 is IDLE.
- HOLD_CYCLES=2, REPEAT=2, mode=1 -> the sequence 00,00,01,01,11,11,10,10 appears twice; wrap=1 only on cycle 9 after start; done on cycle 17 after start.
- pause high for 3 cycles while pos2 is driven -> {b,a}=10 persists for 4 cycles total; total run length grows by 3; done shifts by 3.
- start re-pulsed mid-run and again during the done cycle -> run length unchanged; no second run; mode change ignored.
- rst asserted at pos1 mid-run -> next cycle a=b=0, busy=0, step_idx=0; a subsequent start replays from pos0.
- NUM_STEPS=1, REPEAT=3 -> {b,a}=00 for 3 cycles; wrap pulses on cycles 2 and 3 of DRIVE; done follows.
